// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, consumed by vga_timing and by the image generator
// for its frame-size bounds.
package vga_pkg;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FRONT_DEF  = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BACK_DEF   = 48;
   localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FRONT_DEF  = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BACK_DEF   = 33;
   localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   typedef logic [11:0] coord_t;

   // Half-open window test lo <= v < hi, used for the raw sync conditions.
   function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vga_timing_sync_counter.sv
// Wrap counter: advances when en is high, returns to zero after MAX, and flags the wrap on carry.
module sync_counter #(
   parameter int unsigned       WIDTH = 12,
   parameter logic [WIDTH-1:0]  MAX   = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             carry
);

   logic [WIDTH-1:0] count_r;

   assign count = count_r;
   assign carry = en && (count_r == MAX);

   // Counter register with wrap at MAX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {WIDTH{1'b0}};
      end else if (en) begin
         if (count_r == MAX) begin
            count_r <= {WIDTH{1'b0}};
         end else begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: x/y scan counters, active/frame_tick decode, and a one-stage
// pin register that keeps vga_rgb, hsync and vsync mutually aligned.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FRONT  = H_FRONT_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BACK   = H_BACK_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FRONT  = V_FRONT_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BACK   = V_BACK_DEF
) (
   input  logic        CLOCK_25,
   input  logic        RESET,
   output logic [11:0] x,
   output logic [11:0] y,
   input  logic [2:0]  color_in,
   output logic        active,
   output logic        frame_tick,
   output logic [2:0]  vga_rgb,
   output logic        hsync,
   output logic        vsync
);

   localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
   localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
   localparam coord_t H_TOTAL  = coord_t'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
   localparam coord_t V_TOTAL  = coord_t'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
   localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FRONT);
   localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FRONT);
   localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FRONT + V_SYNC);

   logic       h_wrap_s;
   logic [2:0] rgb_r;
   logic       hsync_r;
   logic       vsync_r;

   sync_counter #(
      .WIDTH (12),
      .MAX   (H_TOTAL - 12'd1)
   ) u_hcount (
      .clk   (CLOCK_25),
      .rst   (RESET),
      .en    (1'b1),
      .count (x),
      .carry (h_wrap_s)
   );

   // The line counter only moves on the edge where the pixel counter wraps.
   sync_counter #(
      .WIDTH (12),
      .MAX   (V_TOTAL - 12'd1)
   ) u_vcount (
      .clk   (CLOCK_25),
      .rst   (RESET),
      .en    (h_wrap_s),
      .count (y),
      .carry ()
   );

   assign active     = (x < H_ACT) && (y < V_ACT);
   assign frame_tick = (x == 12'd0) && (y == V_ACT);

   // Pin stage: color and both syncs share one register so they leave the chip together.
   always_ff @(posedge CLOCK_25 or posedge RESET) begin
      if (RESET) begin
         rgb_r   <= 3'b000;
         hsync_r <= 1'b1;
         vsync_r <= 1'b1;
      end else begin
         rgb_r   <= active ? color_in : 3'b000;
         hsync_r <= ~in_window(x, HS_START, HS_END);
         vsync_r <= ~in_window(y, VS_START, VS_END);
      end
   end

   assign vga_rgb = rgb_r;
   assign hsync   = hsync_r;
   assign vsync   = vsync_r;

endmodule
